// File: rtl/rv32i_types.sv
// Shared RV32I front-end types: machine word, instruction-queue entry and fetch FSM states.
package rv32i_types;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef logic [XLEN-1:0] rv32i_word;

    // Word-align mask applied to redirect targets
    localparam rv32i_word WORD_ALIGN_MASK = ~rv32i_word'(INSTR_BYTES - 1);

    typedef struct packed {
        rv32i_word pc;
        rv32i_word instr;
    } iq_entry_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

endpackage : rv32i_types

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory read, a one-entry hold buffer for queue
// back-pressure, and a drop state that swallows a stale response after a redirect.
module fetch_unit
    import rv32i_types::*;
#(
    parameter rv32i_word RESET_PC = 32'h0000_0060
) (
    input  logic       clk,
    input  logic       rst,
    output logic       instr_read,
    output rv32i_word  instr_mem_address,
    input  logic       instr_mem_resp,
    input  rv32i_word  instr_mem_rdata,
    input  logic       iq_full,
    output logic       iq_push,
    output iq_entry_t  iq_entry,
    input  logic       redirect,
    input  rv32i_word  redirect_pc
);

    fetch_state_e state_q, state_d;
    rv32i_word    req_addr_q, req_addr_d;
    rv32i_word    pend_pc_q, pend_pc_d;
    rv32i_word    hold_buf_q, hold_buf_d;

    rv32i_word    rpc_aligned;
    rv32i_word    req_addr_next;
    logic         resp_ok;

    assign rpc_aligned   = redirect_pc & WORD_ALIGN_MASK;
    assign req_addr_next = req_addr_q + rv32i_word'(INSTR_BYTES);

    assign instr_mem_address = req_addr_q;
    assign iq_entry.pc       = req_addr_q;
    assign iq_entry.instr    = (state_q == HOLD) ? hold_buf_q : instr_mem_rdata;

    // State and address registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            req_addr_q <= RESET_PC;
            pend_pc_q  <= '0;
            hold_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            pend_pc_q  <= pend_pc_d;
            hold_buf_q <= hold_buf_d;
        end
    end

    // Next-state and handshake outputs; reset gates the bus and queue strobes immediately
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        pend_pc_d  = pend_pc_q;
        hold_buf_d = hold_buf_q;
        iq_push    = 1'b0;
        instr_read = !rst && (state_q != HOLD);
        resp_ok    = instr_read && instr_mem_resp;

        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    if (resp_ok) begin
                        req_addr_d = rpc_aligned;
                    end else begin
                        pend_pc_d = rpc_aligned;
                        state_d   = DROP;
                    end
                end else if (resp_ok) begin
                    if (!iq_full) begin
                        iq_push    = 1'b1;
                        req_addr_d = req_addr_next;
                    end else begin
                        hold_buf_d = instr_mem_rdata;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    req_addr_d = rpc_aligned;
                    state_d    = FETCH;
                end else if (!iq_full && !rst) begin
                    iq_push    = 1'b1;
                    req_addr_d = req_addr_next;
                    state_d    = FETCH;
                end
            end
            DROP: begin
                // A redirect arriving with the stale response wins over the pending target
                if (redirect) begin
                    pend_pc_d = rpc_aligned;
                end
                if (resp_ok) begin
                    req_addr_d = redirect ? rpc_aligned : pend_pc_q;
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, redirects, wrap and reset.
module tb_fetch_unit;
    import rv32i_types::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_read;
    rv32i_word  instr_mem_address;
    logic       instr_mem_resp;
    rv32i_word  instr_mem_rdata;
    logic       iq_full;
    logic       iq_push;
    iq_entry_t  iq_entry;
    logic       redirect;
    rv32i_word  redirect_pc;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    fetch_unit #(.RESET_PC(32'h0000_0060)) dut (
        .clk               (clk),
        .rst               (rst),
        .instr_read        (instr_read),
        .instr_mem_address (instr_mem_address),
        .instr_mem_resp    (instr_mem_resp),
        .instr_mem_rdata   (instr_mem_rdata),
        .iq_full           (iq_full),
        .iq_push           (iq_push),
        .iq_entry          (iq_entry),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Apply inputs for the current cycle and let combinational outputs settle
    task automatic drive(input logic resp, input rv32i_word rdata, input logic full,
                         input logic redir, input rv32i_word rpc);
        instr_mem_resp  = resp;
        instr_mem_rdata = rdata;
        iq_full         = full;
        redirect        = redir;
        redirect_pc     = rpc;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic rd, input rv32i_word addr,
                              input logic push, input rv32i_word pc, input rv32i_word ins);
        check_eq({tag, ".read"}, 64'(instr_read), 64'(rd));
        check_eq({tag, ".addr"}, 64'(instr_mem_address), 64'(addr));
        check_eq({tag, ".push"}, 64'(iq_push), 64'(push));
        if (push) begin
            check_eq({tag, ".pc"},    64'(iq_entry.pc),    64'(pc));
            check_eq({tag, ".instr"}, 64'(iq_entry.instr), 64'(ins));
        end
    endtask

    // Assert reset mid-cycle with a response on the bus; it must be ignored
    task automatic do_reset(input string tag);
        rst = 1'b1;
        drive(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0);
        expect_out({tag, ".rst_now"}, 1'b0, 32'h60, 1'b0, 32'h0, 32'h0);
        tick;
        drive(1'b1, 32'hBAD0_BAD1, 1'b0, 1'b0, 32'h0);
        expect_out({tag, ".rst_hold"}, 1'b0, 32'h60, 1'b0, 32'h0, 32'h0);
        tick;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick;
        expect_out("reset", 1'b0, 32'h60, 1'b0, 32'h0, 32'h0);
        tick;
        rst = 1'b0;

        // Zero-wait streaming
        drive(1'b1, 32'hA0, 1'b0, 1'b0, 32'h0); expect_out("s0", 1'b1, 32'h60, 1'b1, 32'h60, 32'hA0); tick;
        drive(1'b1, 32'hA1, 1'b0, 1'b0, 32'h0); expect_out("s1", 1'b1, 32'h64, 1'b1, 32'h64, 32'hA1); tick;
        drive(1'b1, 32'hA2, 1'b0, 1'b0, 32'h0); expect_out("s2", 1'b1, 32'h68, 1'b1, 32'h68, 32'hA2); tick;
        drive(1'b0, 32'h0,  1'b0, 1'b0, 32'h0); expect_out("s3", 1'b1, 32'h6C, 1'b0, 32'h0, 32'h0);  tick;

        // Back-pressure: buffer while full, exactly one push on release
        do_reset("r1");
        drive(1'b1, 32'hB0, 1'b1, 1'b0, 32'h0);        expect_out("h0", 1'b1, 32'h60, 1'b0, 32'h0, 32'h0); tick;
        drive(1'b0, 32'h0,  1'b1, 1'b0, 32'h0);        expect_out("h1", 1'b0, 32'h60, 1'b0, 32'h0, 32'h0); tick;
        drive(1'b0, 32'h0,  1'b1, 1'b0, 32'h0);        expect_out("h2", 1'b0, 32'h60, 1'b0, 32'h0, 32'h0); tick;
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0); expect_out("h3", 1'b0, 32'h60, 1'b1, 32'h60, 32'hB0); tick;
        drive(1'b0, 32'h0,  1'b0, 1'b0, 32'h0);        expect_out("h4", 1'b1, 32'h64, 1'b0, 32'h0, 32'h0); tick;

        // Redirect while a request is outstanding: stale response dropped
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h200);        expect_out("d0", 1'b1, 32'h64, 1'b0, 32'h0, 32'h0); tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);          expect_out("d1", 1'b1, 32'h64, 1'b0, 32'h0, 32'h0); tick;
        drive(1'b1, 32'hDEAD_0001, 1'b0, 1'b0, 32'h0);  expect_out("d2", 1'b1, 32'h64, 1'b0, 32'h0, 32'h0); tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);          expect_out("d3", 1'b1, 32'h200, 1'b0, 32'h0, 32'h0); tick;
        // Misaligned target, then a newer redirect coinciding with the stale response
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h403);        expect_out("d4", 1'b1, 32'h200, 1'b0, 32'h0, 32'h0); tick;
        drive(1'b1, 32'hDEAD_0002, 1'b0, 1'b1, 32'h502); expect_out("d5", 1'b1, 32'h200, 1'b0, 32'h0, 32'h0); tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);          expect_out("d6", 1'b1, 32'h500, 1'b0, 32'h0, 32'h0); tick;

        // Redirect with response in FETCH, then redirect while holding
        drive(1'b1, 32'hCAFE, 1'b0, 1'b1, 32'h300);     expect_out("f0", 1'b1, 32'h500, 1'b0, 32'h0, 32'h0); tick;
        drive(1'b1, 32'hC0,   1'b1, 1'b0, 32'h0);       expect_out("f1", 1'b1, 32'h300, 1'b0, 32'h0, 32'h0); tick;
        drive(1'b0, 32'h0,    1'b0, 1'b1, 32'h700);     expect_out("f2", 1'b0, 32'h300, 1'b0, 32'h0, 32'h0); tick;
        drive(1'b1, 32'hC1,   1'b0, 1'b0, 32'h0);       expect_out("f3", 1'b1, 32'h700, 1'b1, 32'h700, 32'hC1); tick;

        // Address wrap at the top of memory
        drive(1'b1, 32'hCAFE, 1'b0, 1'b1, 32'hFFFF_FFFC); expect_out("w0", 1'b1, 32'h704, 1'b0, 32'h0, 32'h0); tick;
        drive(1'b1, 32'hD0,   1'b0, 1'b0, 32'h0);         expect_out("w1", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'hD0); tick;
        drive(1'b0, 32'h0,    1'b0, 1'b0, 32'h0);         expect_out("w2", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0); tick;

        // Reset mid-request; late response belongs to the RESET_PC request
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        do_reset("r2");
        drive(1'b1, 32'hE0, 1'b0, 1'b0, 32'h0); expect_out("l0", 1'b1, 32'h60, 1'b1, 32'h60, 32'hE0); tick;
        drive(1'b0, 32'h0,  1'b0, 1'b0, 32'h0); expect_out("l1", 1'b1, 32'h64, 1'b0, 32'h0, 32'h0);   tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit
